regs_op_sequencer: RTL and testbench

- Command-side initiator for the 32x8 register file (regs32x8); drives its read_a/read_b/write/clear interface.
- Accepts one 3-address operation at a time over a valid/ready handshake.
- Reads up to two source registers, computes a 32-bit ALU result and writes it back to the destination register.
- Sits between the instruction/control front end and the register file.

---
 rtl/regs_op_sequencer.sv | 159 +++++++++++++++
 tb/tb_regs_op_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regs_op_sequencer.sv
// Command-side sequencer for the 32x8 register file. It accepts one 3-address
// operation at a time, reads its sources, runs the ALU and writes the result back.
module regs_op_sequencer #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [AW-1:0] op_dst,
  input  logic [AW-1:0] op_src1,
  input  logic [AW-1:0] op_src2,
  input  logic [DW-1:0] op_imm,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          rf_read_a,
  output logic [AW-1:0] rf_a_addr,
  input  logic [DW-1:0] rf_a,
  output logic          rf_read_b,
  output logic [AW-1:0] rf_b_addr,
  input  logic [DW-1:0] rf_b,
  output logic          rf_write,
  output logic [AW-1:0] rf_in_addr,
  output logic [DW-1:0] rf_in,
  output logic          rf_clear
);

  localparam int SW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MOVI = 3'b101,
    OP_SHL  = 3'b110,
    OP_CLR  = 3'b111
  } opcode_t;

  state_t  state, state_nxt;
  opcode_t code_q;
  logic [AW-1:0] dst_q, src1_q, src2_q;
  logic [DW-1:0] imm_q, opa_q, opb_q, res_q;

  logic accept;
  logic uses_rf;

  assign accept  = op_valid && (state == IDLE);
  // MOVI and CLR never touch the read ports.
  assign uses_rf = (code_q != OP_MOVI) && (code_q != OP_CLR);

  function automatic logic [DW-1:0] alu(input opcode_t c, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [DW-1:0] imm);
    logic [DW-1:0] r;
    // NOTE: defaulting every variable first keeps combinational code latch-free.
    r = '0;
    unique case (c)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOVI: r = imm;
      OP_SHL:  r = a << b[SW-1:0];
      OP_CLR:  r = '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RD;
      RD:      state_nxt = EX;
      EX:      state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: these are a handful of flops, not a memory, so they all take the
  // async reset; a reset mid-operation must leave nothing stale behind.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      code_q <= OP_ADD;
      dst_q  <= '0;
      src1_q <= '0;
      src2_q <= '0;
      imm_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        code_q <= opcode_t'(op_code);
        dst_q  <= op_dst;
        src1_q <= op_src1;
        src2_q <= op_src2;
        imm_q  <= op_imm;
      end
      // Operands are captured here, so a dst that aliases a source sees the old value.
      if (state == RD) begin
        opa_q <= rf_read_a ? rf_a : '0;
        opb_q <= rf_read_b ? rf_b : '0;
      end
      if (state == EX) res_q <= alu(code_q, opa_q, opb_q, imm_q);
    end
  end

  always_comb begin
    op_ready   = (state == IDLE);
    done       = 1'b0;
    result     = '0;
    rf_read_a  = 1'b0;
    rf_a_addr  = '0;
    rf_read_b  = 1'b0;
    rf_b_addr  = '0;
    rf_write   = 1'b0;
    rf_in_addr = '0;
    rf_in      = '0;
    rf_clear   = 1'b0;
    unique case (state)
      RD: begin
        if (uses_rf) begin
          rf_read_a = 1'b1;
          rf_a_addr = src1_q;
          rf_read_b = 1'b1;
          rf_b_addr = src2_q;
        end
      end
      WB: begin
        done   = 1'b1;
        result = res_q;
        if (code_q == OP_CLR) begin
          rf_clear = 1'b1;
        end else begin
          rf_write   = 1'b1;
          rf_in_addr = dst_q;
          rf_in      = res_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regs_op_sequencer.sv
// Directed bench for regs_op_sequencer with a small behavioural register file
// (combinational reads, writes and clear at the clock edge).
module tb_regs_op_sequencer;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          m_clock = 1'b0;
  logic          p_reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [AW-1:0] op_dst, op_src1, op_src2;
  logic [DW-1:0] op_imm;
  logic          done;
  logic [DW-1:0] result;
  logic          rf_read_a, rf_read_b, rf_write, rf_clear;
  logic [AW-1:0] rf_a_addr, rf_b_addr, rf_in_addr;
  logic [DW-1:0] rf_a, rf_b, rf_in;

  logic [DW-1:0] mem [8] = '{default: '0};

  int checks   = 0;
  int failures = 0;
  int waits;

  regs_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_dst(op_dst), .op_src1(op_src1), .op_src2(op_src2), .op_imm(op_imm),
    .done(done), .result(result),
    .rf_read_a(rf_read_a), .rf_a_addr(rf_a_addr), .rf_a(rf_a),
    .rf_read_b(rf_read_b), .rf_b_addr(rf_b_addr), .rf_b(rf_b),
    .rf_write(rf_write), .rf_in_addr(rf_in_addr), .rf_in(rf_in),
    .rf_clear(rf_clear)
  );

  always #5 m_clock = ~m_clock;

  assign rf_a = rf_read_a ? mem[rf_a_addr] : '0;
  assign rf_b = rf_read_b ? mem[rf_b_addr] : '0;

  always @(posedge m_clock) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (rf_write) begin
      mem[rf_in_addr] <= rf_in;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op and wait (bounded) until it is accepted; scramble inputs afterwards.
  task automatic issue(input logic [2:0] c, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                       input logic [AW-1:0] s2, input logic [DW-1:0] imm, input bit hold,
                       output int n);
    op_valid = 1'b1;
    op_code  = c;
    op_dst   = d;
    op_src1  = s1;
    op_src2  = s2;
    op_imm   = imm;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge m_clock);
      n++;
    end
    check("accept_bound", 32'(n < 20), 32'd1);
    @(posedge m_clock);
    #1;
    if (!hold) begin
      op_valid = 1'b0;
      op_code  = 3'($urandom);
      op_dst   = 3'($urandom);
      op_src1  = 3'($urandom);
      op_src2  = 3'($urandom);
      op_imm   = $urandom;
    end
  endtask

  // Check the RD, EX, WB and following IDLE cycles of an accepted op.
  task automatic follow(input string nm, input bit rd, input logic [AW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2, input bit clr,
                        input logic [DW-1:0] exp);
    @(negedge m_clock);
    check({nm, ".rd.ready"},  32'(op_ready), 32'd0);
    check({nm, ".rd.done"},   32'(done), 32'd0);
    check({nm, ".rd.read_a"}, 32'(rf_read_a), 32'(rd));
    check({nm, ".rd.a_addr"}, 32'(rf_a_addr), rd ? 32'(s1) : 32'd0);
    check({nm, ".rd.read_b"}, 32'(rf_read_b), 32'(rd));
    check({nm, ".rd.b_addr"}, 32'(rf_b_addr), rd ? 32'(s2) : 32'd0);
    check({nm, ".rd.write"},  32'(rf_write), 32'd0);
    @(negedge m_clock);
    check({nm, ".ex.done"},   32'(done), 32'd0);
    check({nm, ".ex.read_a"}, 32'(rf_read_a), 32'd0);
    check({nm, ".ex.result"}, result, 32'd0);
    check({nm, ".ex.write"},  32'(rf_write), 32'd0);
    @(negedge m_clock);
    check({nm, ".wb.done"},    32'(done), 32'd1);
    check({nm, ".wb.ready"},   32'(op_ready), 32'd0);
    check({nm, ".wb.result"},  result, exp);
    check({nm, ".wb.write"},   32'(rf_write), clr ? 32'd0 : 32'd1);
    check({nm, ".wb.in_addr"}, 32'(rf_in_addr), clr ? 32'd0 : 32'(d));
    check({nm, ".wb.in"},      rf_in, clr ? 32'd0 : exp);
    check({nm, ".wb.clear"},   32'(rf_clear), 32'(clr));
    @(negedge m_clock);
    check({nm, ".idle.done"},  32'(done), 32'd0);
    check({nm, ".idle.ready"}, 32'(op_ready), 32'd1);
    check({nm, ".idle.write"}, 32'(rf_write), 32'd0);
    check({nm, ".idle.clear"}, 32'(rf_clear), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    p_reset  = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'b101;
    op_dst   = 3'd1;
    op_src1  = 3'd0;
    op_src2  = 3'd0;
    op_imm   = 32'h0000_0005;

    // Reset held with a pending request: nothing may be issued.
    repeat (3) begin
      @(negedge m_clock);
      check("reset.write",  32'(rf_write), 32'd0);
      check("reset.clear",  32'(rf_clear), 32'd0);
      check("reset.read_a", 32'(rf_read_a), 32'd0);
      check("reset.ready",  32'(op_ready), 32'd1);
      check("reset.done",   32'(done), 32'd0);
    end
    p_reset = 1'b0;
    #1;
    check("post_reset.ready",   32'(op_ready), 32'd1);
    check("post_reset.done",    32'(done), 32'd0);
    check("post_reset.in",      rf_in, 32'd0);
    check("post_reset.in_addr", 32'(rf_in_addr), 32'd0);
    check("post_reset.read_b",  32'(rf_read_b), 32'd0);

    issue(3'b101, 3'd1, 3'd0, 3'd0, 32'h0000_0005, 1'b0, waits);
    check("first_accept_wait", 32'(waits), 32'd0);
    follow("movi_r1", 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 32'h0000_0005);
    issue(3'b101, 3'd2, 3'd0, 3'd0, 32'hFFFF_FFFE, 1'b0, waits);
    follow("movi_r2", 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 32'hFFFF_FFFE);
    issue(3'b000, 3'd3, 3'd1, 3'd2, 32'h0, 1'b0, waits);
    follow("add_r3", 1'b1, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0000_0003);
    issue(3'b001, 3'd4, 3'd2, 3'd1, 32'h0, 1'b0, waits);
    follow("sub_r4", 1'b1, 3'd4, 3'd2, 3'd1, 1'b0, 32'hFFFF_FFF9);
    issue(3'b110, 3'd5, 3'd1, 3'd1, 32'h0, 1'b0, waits);
    follow("shl_r5", 1'b1, 3'd5, 3'd1, 3'd1, 1'b0, 32'h0000_00A0);
    issue(3'b101, 3'd6, 3'd0, 3'd0, 32'h0000_0021, 1'b0, waits);
    follow("movi_r6", 1'b0, 3'd6, 3'd0, 3'd0, 1'b0, 32'h0000_0021);
    issue(3'b110, 3'd7, 3'd1, 3'd6, 32'h0, 1'b0, waits);
    follow("shl_r7", 1'b1, 3'd7, 3'd1, 3'd6, 1'b0, 32'h0000_000A);
    check("mem.r3", mem[3], 32'h0000_0003);
    check("mem.r4", mem[4], 32'hFFFF_FFF9);
    check("mem.r7", mem[7], 32'h0000_000A);

    // Back-to-back with op_valid held high; second op reads r3 just written.
    issue(3'b000, 3'd3, 3'd1, 3'd2, 32'h0, 1'b1, waits);
    op_dst  = 3'd6;
    op_src1 = 3'd3;
    op_src2 = 3'd3;
    follow("held_add_r3", 1'b1, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0000_0003);
    issue(3'b000, 3'd6, 3'd3, 3'd3, 32'h0, 1'b0, waits);
    check("held.gap_wait", 32'(waits), 32'd0);
    follow("held_add_r6", 1'b1, 3'd6, 3'd3, 3'd3, 1'b0, 32'h0000_0006);
    check("mem.r6", mem[6], 32'h0000_0006);

    issue(3'b111, 3'd0, 3'd0, 3'd0, 32'h0, 1'b0, waits);
    follow("clr", 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 32'h0);
    check("clr.mem.r3", mem[3], 32'h0);
    check("clr.mem.r6", mem[6], 32'h0);
    issue(3'b000, 3'd0, 3'd3, 3'd4, 32'h0, 1'b0, waits);
    follow("add_r0", 1'b1, 3'd0, 3'd3, 3'd4, 1'b0, 32'h0);

    issue(3'b101, 3'd7, 3'd0, 3'd0, 32'h0000_0077, 1'b0, waits);
    follow("movi_r7", 1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 32'h0000_0077);
    issue(3'b101, 3'd1, 3'd0, 3'd0, 32'h0000_0009, 1'b0, waits);
    follow("movi_r1b", 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 32'h0000_0009);

    // Reset lands in EX of ADD r7=r1+r1: the write must never happen.
    issue(3'b000, 3'd7, 3'd1, 3'd1, 32'h0, 1'b0, waits);
    @(negedge m_clock);
    check("abort.rd.read_a", 32'(rf_read_a), 32'd1);
    @(negedge m_clock);
    p_reset = 1'b1;
    #1;
    check("abort.ready", 32'(op_ready), 32'd1);
    check("abort.write", 32'(rf_write), 32'd0);
    check("abort.done",  32'(done), 32'd0);
    @(negedge m_clock);
    check("abort.hold.write", 32'(rf_write), 32'd0);
    check("abort.hold.clear", 32'(rf_clear), 32'd0);
    p_reset = 1'b0;
    @(negedge m_clock);
    check("abort.after.ready", 32'(op_ready), 32'd1);
    check("abort.after.write", 32'(rf_write), 32'd0);
    check("abort.mem.r7",      mem[7], 32'h0000_0077);

    issue(3'b100, 3'd2, 3'd7, 3'd1, 32'h0, 1'b0, waits);
    follow("xor_r2", 1'b1, 3'd2, 3'd7, 3'd1, 1'b0, 32'h0000_007E);
    issue(3'b010, 3'd3, 3'd7, 3'd1, 32'h0, 1'b0, waits);
    follow("and_r3", 1'b1, 3'd3, 3'd7, 3'd1, 1'b0, 32'h0000_0001);
    issue(3'b011, 3'd4, 3'd7, 3'd1, 32'h0, 1'b0, waits);
    follow("or_r4", 1'b1, 3'd4, 3'd7, 3'd1, 1'b0, 32'h0000_007F);
    check("mem.r2", mem[2], 32'h0000_007E);
    check("mem.r4b", mem[4], 32'h0000_007F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
